mbist_addr_seq: RTL



---
 rtl/mbist_addr_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mbist_addr_seq.sv
// MBIST address sequencer: row/column walk with non-power-of-two bounds, selectable order/direction.
// Optional checkerboard background output when MBIST_AG_CHKB_EN is defined (adds bg_inv/bg_bit ports).
module mbist_addr_seq #(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 4,
   parameter int ROW_LAST = 2**ROW_BITS-1,
   parameter int COL_LAST = 2**COL_BITS-1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         dir,
   input  logic                         order,
   input  logic                         step,
   input  logic                         abort,
`ifdef MBIST_AG_CHKB_EN
   input  logic                         bg_inv,
   output logic                         bg_bit,
`endif
   output logic [ROW_BITS+COL_BITS-1:0] addr,
   output logic                         addr_vld,
   output logic                         last,
   output logic                         busy,
   output logic                         done
);

   localparam logic [ROW_BITS-1:0] ROW_L   = ROW_BITS'(ROW_LAST);
   localparam logic [COL_BITS-1:0] COL_L   = COL_BITS'(COL_LAST);
   localparam logic [ROW_BITS-1:0] ROW_ONE = ROW_BITS'(1);
   localparam logic [COL_BITS-1:0] COL_ONE = COL_BITS'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [ROW_BITS-1:0] row_q, row_d, row_nxt;
   logic [COL_BITS-1:0] col_q, col_d, col_nxt;
   logic                dir_q, dir_d, order_q, order_d;
   logic                row_wrap, col_wrap, at_term;
`ifdef MBIST_AG_CHKB_EN
   logic                bg_inv_q, bg_inv_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         row_q    <= '0;
         col_q    <= '0;
         dir_q    <= 1'b0;
         order_q  <= 1'b0;
`ifdef MBIST_AG_CHKB_EN
         bg_inv_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         dir_q    <= dir_d;
         order_q  <= order_d;
`ifdef MBIST_AG_CHKB_EN
         bg_inv_q <= bg_inv_d;
`endif
      end
   end

   // Per-axis wrap against the configured last index, not all-ones.
   assign row_wrap = dir_q ? (row_q == '0) : (row_q == ROW_L);
   assign col_wrap = dir_q ? (col_q == '0) : (col_q == COL_L);
   assign row_nxt  = dir_q ? (row_wrap ? ROW_L : row_q - ROW_ONE)
                           : (row_wrap ? '0    : row_q + ROW_ONE);
   assign col_nxt  = dir_q ? (col_wrap ? COL_L : col_q - COL_ONE)
                           : (col_wrap ? '0    : col_q + COL_ONE);
   assign at_term  = dir_q ? (row_q == '0 && col_q == '0)
                           : (row_q == ROW_L && col_q == COL_L);

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      dir_d    = dir_q;
      order_d  = order_q;
`ifdef MBIST_AG_CHKB_EN
      bg_inv_d = bg_inv_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d  = S_RUN;
               dir_d    = dir;
               order_d  = order;
               row_d    = dir ? ROW_L : '0;
               col_d    = dir ? COL_L : '0;
`ifdef MBIST_AG_CHKB_EN
               bg_inv_d = bg_inv;
`endif
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               row_d   = '0;
               col_d   = '0;
            end else if (step) begin
               if (at_term) begin
                  state_d = S_DONE;
               end else if (!order_q) begin
                  col_d = col_nxt;
                  if (col_wrap) row_d = row_nxt;
               end else begin
                  row_d = row_nxt;
                  if (row_wrap) col_d = col_nxt;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (abort) begin
               row_d = '0;
               col_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      addr     = {row_q, col_q};
      addr_vld = (state_q == S_RUN);
      last     = (state_q == S_RUN) && at_term;
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
`ifdef MBIST_AG_CHKB_EN
      bg_bit   = (state_q == S_RUN) && (row_q[0] ^ col_q[0] ^ bg_inv_q);
`endif
   end

endmodule
